// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Buffered asynchronous serial transmitter. Characters are queued in a
//   small FIFO and sent as frames: one start bit (0), char_size data bits
//   LSB first, then one or two stop bits (1). One bit per baud period.
//
// Ports
//   baud       in   bit clock; every state change happens on its rising edge
//   rst        in   asynchronous active-high reset
//   char_size  in   data bits per character (values clamp to 5..8)
//   stop2      in   0 = one stop bit, 1 = two stop bits
//   tx_en      in   permits starting a new frame
//   data_in    in   character to enqueue (bits above char_size ignored)
//   wr_en      in   enqueue data_in on this edge
//   full       out  FIFO holds FIFO_DEPTH entries
//   ovf        out  sticky: a write was dropped because the FIFO was full
//   rdy        out  FIFO empty and no frame in progress
//   tx         out  serial line, registered, idle high
//   state_dbg  out  current FSM state (0 = IDLE, 1 = DATA, 2 = STOP)
//
// Write handshake: wr_en is a one-cycle request with full acting as the
// inverse of ready. A write is accepted on an edge where wr_en=1 and the
// registered full=0; a write on an edge where full=1 is dropped and sets
// ovf, even if a character is popped on that same edge.

module uart_transmitter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       baud,
    input  logic       rst,
    input  logic [3:0] char_size,
    input  logic       stop2,
    input  logic       tx_en,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       ovf,
    output logic       rdy,
    output logic       tx,
    output logic [1:0] state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t        state;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [7:0]    shreg;      // remaining data bits, shifted out LSB first
    logic [3:0]    bit_cnt;    // data bits already driven in this frame
    logic [3:0]    n_bits;     // clamped char_size latched at frame start
    logic          stop2_q;    // stop2 latched at frame start
    logic          stop_cnt;   // 1 while in the second of two stop periods

    logic          empty;
    logic          push;
    logic          pop;
    logic          last_stop;
    logic [3:0]    size_clamped;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign rdy   = empty && (state == IDLE);
    assign state_dbg = state;

    // The edge that ends the final stop period; a new frame may start here
    // directly so back-to-back frames have no idle gap.
    assign last_stop = (state == STOP) && (!stop2_q || stop_cnt);

    // Pop decisions use the registered count, so a character written on the
    // same edge that IDLE sees an empty FIFO only starts on the next edge.
    assign pop  = tx_en && !empty && ((state == IDLE) || last_stop);
    assign push = wr_en && !full;

    always_comb begin
        size_clamped = char_size;
        if (char_size < 4'd5) begin
            size_clamped = 4'd5;
        end else if (char_size > 4'd8) begin
            size_clamped = 4'd8;
        end
    end

    // FIFO storage: no reset needed, the pointers define what is valid.
    always_ff @(posedge baud) begin
        if (push && !rst) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, occupancy and overflow flag. Pointers wrap naturally
    // because FIFO_DEPTH is a power of two.
    always_ff @(posedge baud or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Frame sequencer. pop is only ever true in IDLE or at the last stop
    // edge, so it is handled first as the common "start a frame" action.
    always_ff @(posedge baud or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            n_bits   <= 4'd8;
            stop2_q  <= 1'b0;
            stop_cnt <= 1'b0;
        end else if (pop) begin
            tx       <= 1'b0;
            shreg    <= mem[rd_ptr];
            n_bits   <= size_clamped;
            stop2_q  <= stop2;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= DATA;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                end
                DATA: begin
                    if (bit_cnt == n_bits) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (last_stop) begin
                        state <= IDLE;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//   Self-checking bench for uart_transmitter. Expected frames (start, data,
//   stop bits packed LSB-first into 12 bits) are queued when a character is
//   written; a line monitor captures each frame from its start bit and
//   compares it against the head of the queue.

module tb_uart_transmitter;

    logic       baud;
    logic       rst;
    logic [3:0] char_size;
    logic       stop2;
    logic       tx_en;
    logic [7:0] data_in;
    logic       wr_en;
    logic       full;
    logic       ovf;
    logic       rdy;
    logic       tx;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int frames_exp = 0;
    int frames_done = 0;
    int cyc = 0;

    logic [11:0] exp_q[$];
    int          len_q[$];
    int          start_cyc[$];

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  size;
        logic        stop2;
        logic [11:0] frame;
        int          len;
    } vec_t;

    vec_t vecs[6];

    uart_transmitter #(.FIFO_DEPTH(4)) dut (
        .baud      (baud),
        .rst       (rst),
        .char_size (char_size),
        .stop2     (stop2),
        .tx_en     (tx_en),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .full      (full),
        .ovf       (ovf),
        .rdy       (rdy),
        .tx        (tx),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial baud = 1'b0;
    always #5 baud = ~baud;

    always @(posedge baud) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge baud);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [11:0] f, input int len, input bit expect_it);
        wr_en   = 1'b1;
        data_in = d;
        if (expect_it) begin
            exp_q.push_back(f);
            len_q.push_back(len);
            frames_exp++;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while (frames_done < target && n < 400) begin
            tick();
            n++;
        end
        check(name, 32'(frames_done >= target), 32'd1);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(tx), 32'd0);
    endtask

    // ---------------- line monitor / scoreboard ----------------
    initial begin : monitor
        logic [11:0] cap;
        logic [11:0] want;
        int          len;
        bit          aborted;
        forever begin
            @(posedge baud);
            #1;
            if (!rst && tx === 1'b0) begin
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 32'(tx), 32'd1);
                end else begin
                    want    = exp_q.pop_front();
                    len     = len_q.pop_front();
                    cap     = '0;
                    aborted = 1'b0;
                    for (int k = 1; k < len; k++) begin
                        @(posedge baud);
                        #1;
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        cap[k] = tx;
                    end
                    if (!aborted) begin
                        check("frame", 32'(cap), 32'(want));
                        frames_done++;
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        bit all_high;
        bit all_rdy;
        int n0;

        rst       = 1'b0;
        char_size = 4'd8;
        stop2     = 1'b0;
        tx_en     = 1'b0;
        data_in   = 8'h00;
        wr_en     = 1'b0;

        vecs[0] = '{data: 8'hA5, size: 4'd8,  stop2: 1'b0, frame: 12'h34A, len: 10};
        vecs[1] = '{data: 8'hFF, size: 4'd5,  stop2: 1'b0, frame: 12'h07E, len: 7};
        vecs[2] = '{data: 8'h3C, size: 4'd7,  stop2: 1'b1, frame: 12'h378, len: 10};
        vecs[3] = '{data: 8'h96, size: 4'd6,  stop2: 1'b0, frame: 12'h0AC, len: 8};
        vecs[4] = '{data: 8'h5A, size: 4'd2,  stop2: 1'b0, frame: 12'h074, len: 7};
        vecs[5] = '{data: 8'hC3, size: 4'd15, stop2: 1'b1, frame: 12'h786, len: 11};

        // reset state, checked before any clock edge reaches the DUT
        #2 rst = 1'b1;
        #1;
        check("reset_tx",   32'(tx),   32'd1);
        check("reset_rdy",  32'(rdy),  32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single characters of various sizes; char_size/stop2 are scrambled
        // once the frame has started and must not disturb it
        for (int i = 0; i < 6; i++) begin
            char_size = vecs[i].size;
            stop2     = vecs[i].stop2;
            tx_en     = 1'b1;
            send(vecs[i].data, vecs[i].frame, vecs[i].len, 1'b1);
            wait_start($sformatf("vec%0d_start", i));
            char_size = 4'($urandom_range(0, 15));
            stop2     = 1'($urandom_range(0, 1));
            wait_frames(frames_exp, $sformatf("vec%0d_done", i));
            tick();
            check($sformatf("vec%0d_rdy", i), 32'(rdy), 32'd1);
            check($sformatf("vec%0d_idle_tx", i), 32'(tx), 32'd1);
        end

        // back-to-back with two stop bits: start bits exactly 11 periods apart
        char_size = 4'd8;
        stop2     = 1'b1;
        tx_en     = 1'b1;
        n0 = start_cyc.size();
        send(8'h00, 12'h600, 11, 1'b1);
        send(8'hFF, 12'h7FE, 11, 1'b1);
        wait_frames(frames_exp, "b2b_done");
        tick();
        check("b2b_rdy", 32'(rdy), 32'd1);
        if (start_cyc.size() >= n0 + 2) begin
            check("b2b_gap", 32'(start_cyc[n0+1] - start_cyc[n0]), 32'd11);
        end else begin
            check("b2b_starts", 32'(start_cyc.size() - n0), 32'd2);
        end

        // overflow: fifth write dropped, first four sent in order
        stop2 = 1'b0;
        tx_en = 1'b0;
        send(8'h11, 12'h222, 10, 1'b1);
        send(8'h22, 12'h244, 10, 1'b1);
        send(8'h33, 12'h266, 10, 1'b1);
        check("ovf_full_at3", 32'(full), 32'd0);
        send(8'h44, 12'h288, 10, 1'b1);
        check("ovf_full_at4", 32'(full), 32'd1);
        check("ovf_clear_at4", 32'(ovf), 32'd0);
        send(8'h55, 12'h000, 10, 1'b0);
        check("ovf_set_at5", 32'(ovf), 32'd1);
        check("ovf_full_at5", 32'(full), 32'd1);
        check("ovf_rdy_busy", 32'(rdy), 32'd0);
        tx_en = 1'b1;
        wait_frames(frames_exp, "ovf_drain");
        tick();
        check("ovf_rdy_after", 32'(rdy), 32'd1);
        check("ovf_full_after", 32'(full), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // tx_en dropped during the third data bit with two characters queued
        tx_en = 1'b1;
        send(8'hA1, 12'h342, 10, 1'b1);
        send(8'h5E, 12'h2BC, 10, 1'b1);
        check("drop_start", 32'(tx), 32'd0);
        tick();
        tick();
        tick();
        tx_en = 1'b0;
        wait_frames(frames_exp - 1, "drop_first_done");
        tick();
        all_high = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (tx !== 1'b1) all_high = 1'b0;
        end
        check("drop_line_high", 32'(all_high), 32'd1);
        check("drop_rdy_low", 32'(rdy), 32'd0);
        tx_en = 1'b1;
        tick();
        check("drop_resume_start", 32'(tx), 32'd0);
        wait_frames(frames_exp, "drop_second_done");
        tick();
        check("drop_rdy_after", 32'(rdy), 32'd1);

        // reset during data bit 4 with two characters queued
        char_size = 4'd8;
        stop2     = 1'b0;
        tx_en     = 1'b1;
        send(8'h00, 12'h200, 10, 1'b1);
        send(8'h00, 12'h200, 10, 1'b1);
        check("rst_frame_start", 32'(tx), 32'd0);
        repeat (5) tick();
        check("rst_bit4_low", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_tx_async",   32'(tx),   32'd1);
        check("rst_rdy_async",  32'(rdy),  32'd1);
        check("rst_full_async", 32'(full), 32'd0);
        check("rst_ovf_async",  32'(ovf),  32'd0);
        exp_q.delete();
        len_q.delete();
        frames_exp = frames_done;
        // writes while reset is held must be ignored
        wr_en   = 1'b1;
        data_in = 8'h0F;
        tick();
        tick();
        wr_en = 1'b0;
        rst   = 1'b0;
        all_high = 1'b1;
        all_rdy  = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (tx !== 1'b1) all_high = 1'b0;
            if (rdy !== 1'b1) all_rdy = 1'b0;
        end
        check("rst_no_frames", 32'(all_high), 32'd1);
        check("rst_fifo_empty", 32'(all_rdy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
